bf_weight_loader: RTL
=====================

# bf_weight_loader

Double-buffered loader for the beamformer steering weights, sitting directly upstream of the beamformer top and driving its `w_cos_1`/`w_sin_1`/`w_cos_2`/`w_sin_2` weight arrays.

- A host or controller streams a 32-word frame into a shadow bank over a valid/ready handshake.
- An `apply` strobe then copies all 32 weights into the active bank on a single clock edge.
- The phase shifters therefore never see a partially updated weight set.
- Framing errors are flagged, and the number of committed frames is counted.

## Interface
Parameters:
- `NCH`, 8, number of beamformer channels.
- `WW`, 5, weight word width (signed two's complement).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset: state is cleared on a `clock` edge where `reset`==0.
- `s_valid`  in  1  a weight word is present.
- `s_ready`  out  1  loader accepts a word this cycle.
- `s_sof`  in  1  start of frame, qualifies word 0.
- `s_data`  in  WW  weight word.
- `apply`  in  1  commit request: moves the shadow bank to the active bank.
- `w_cos_1`, `w_sin_1`, `w_cos_2`, `w_sin_2`  out  WW x NCH each  active weights, unpacked arrays indexed [NCH-1:0].
- `full`  out  1  a complete frame is waiting in the shadow bank.
- `frame_err`  out  1  sticky framing-error flag.
- `upd_cnt`  out  8  count of committed frames.

## Operation
Handshake and word addressing:
- A beat is accepted when `s_valid` && `s_ready` at a `clock` edge.
- Word index k = 0..31 maps to set k[4:3] and channel k[2:0].
- Set 0 = `w_cos_1`, 1 = `w_sin_1`, 2 = `w_cos_2`, 3 = `w_sin_2`.
- `s_data` is stored unmodified; no sign extension or saturation is applied.

FSM states are IDLE, LOAD and FULL:
- IDLE, `s_ready`=1:
  - Accepted beat with `s_sof`=1: write shadow[0], set cnt=1, go to LOAD.
  - Accepted beat with `s_sof`=0: word dropped, `frame_err` set, stay in IDLE.
- LOAD, `s_ready`=1:
  - Accepted beat with `s_sof`=0: write shadow[cnt], increment cnt.
  - When the beat written is index 31, go to FULL.
  - Accepted beat with `s_sof`=1 (premature restart): set `frame_err`, write the word as index 0, set cnt=1, stay in LOAD.
  - Stale shadow entries are overwritten by the new frame.
- FULL, `s_ready`=0, `full`=1:
  - `apply`=1: copy all 4 x NCH shadow words to the active bank on that edge, increment `upd_cnt`, clear `frame_err`, go to IDLE.
  - `apply`=0: hold indefinitely; the shadow bank is retained.

Other rules:
- `apply` in IDLE or LOAD is ignored: the active bank, `upd_cnt` and `frame_err` are unchanged.
- `upd_cnt` wraps from 255 to 0.
- The shadow bank is never cleared except by reset. A new frame overwrites every entry, so leftover data from an aborted frame cannot reach the active bank.

## Timing
Reset values while `reset`==0 and on the first cycle after release:
- All active and shadow weights are 0 and the FSM is in IDLE.
- `full`=0, `frame_err`=0, `upd_cnt`=0.
- `s_ready`=0 while `reset`==0, and 1 from the first cycle after release.

Cycle-level behaviour:
- `s_ready` and `full` are decoded combinationally from the registered state and do not depend on `s_valid` in the same cycle.
- Maximum throughput is one word per cycle.
- A frame of 32 back-to-back beats makes `full`=1 on the cycle after the 32nd accepting edge.
- Apply latency: new weights appear on the outputs on the cycle after the edge that samples `apply` in FULL.
- All 4 x NCH outputs change on that same edge.
- `s_ready` returns to 1 on the same cycle the new weights appear.
- If `reset` is asserted mid-frame or in FULL, the partial or pending frame is discarded and the active weights return to 0.
- The weight outputs come directly from flops, with no combinational path from any input.

## Structure
Package `bf_pkg` holds:
- `NCH`, `WW`, and `BF_FRAME_WORDS`=32.
- The set encoding constants (`SET_COS1`=0, `SET_SIN1`=1, `SET_COS2`=2, `SET_SIN2`=3).
- The loader state enum (IDLE, LOAD, FULL).

Sub-modules:
- `bf_weight_bank` holds the shadow and active register files. It takes a write port (index, data, we) and a `commit` strobe, and exposes the four active arrays.
- The FSM, counter and flags live in `bf_weight_loader`.

## Test plan
- Reset, then a 32-beat frame with k-th word = k[4:0] (`s_sof` on k=0), then `apply`:
  - before `apply`: `full`=1 and outputs are 0;
  - one cycle after `apply`: `w_sin_1[3]`=11, `w_sin_2[7]`=31, `upd_cnt`=1.
- Frame with `s_valid` toggling every other cycle, then `apply`: same final weights as the back-to-back load; `s_ready` is never 1 while `full`=1.
- Second `s_sof` at word 10, then a full 32-word frame of 5'h1F, then `apply`:
  - `frame_err`=1 after the restart;
  - after `apply`: all weights 5'h1F and `frame_err`=0.
- Word without `s_sof` in IDLE: `frame_err`=1, state stays IDLE. `apply` in IDLE: outputs and `upd_cnt` unchanged.
- 256 committed frames: `upd_cnt` wraps to 0.
- Reset asserted in FULL: outputs become 0, `full`=0, and `s_ready`=1 one cycle after release.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared constants, set encoding and loader state type for the beamformer weight loader.
package bf_pkg;

  localparam int unsigned NCH            = 8;
  localparam int unsigned WW             = 5;
  localparam int unsigned BF_FRAME_WORDS = 32;

  // Word index bits [4:3] select one of these weight sets.
  localparam logic [1:0] SET_COS1 = 2'd0;
  localparam logic [1:0] SET_SIN1 = 2'd1;
  localparam logic [1:0] SET_COS2 = 2'd2;
  localparam logic [1:0] SET_SIN2 = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } bf_state_e;

endpackage

// File: rtl/bf_weight_loader_if.sv
// Valid/ready weight stream into the loader; word 0 of each frame is tagged by s_sof.
interface bf_weight_loader_if #(
  parameter int unsigned WW = bf_pkg::WW
);

  logic          s_valid;
  logic          s_ready;
  logic          s_sof;
  logic [WW-1:0] s_data;

  modport master (
    output s_valid,
    output s_sof,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_sof,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/bf_weight_bank.sv
// Shadow and active weight register files; commit copies the whole shadow bank in one edge.
module bf_weight_bank #(
  parameter int unsigned NCH = bf_pkg::NCH,
  parameter int unsigned WW  = bf_pkg::WW,
  parameter int unsigned IW  = $clog2(4 * NCH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IW-1:0]        wr_idx,
  input  logic [WW-1:0]        wr_data,
  input  logic                 commit,
  output logic signed [WW-1:0] w_cos_1 [NCH-1:0],
  output logic signed [WW-1:0] w_sin_1 [NCH-1:0],
  output logic signed [WW-1:0] w_cos_2 [NCH-1:0],
  output logic signed [WW-1:0] w_sin_2 [NCH-1:0]
);

  import bf_pkg::*;

  localparam int unsigned CW = $clog2(NCH);

  typedef logic signed [WW-1:0] w_t;

  w_t shadow_q [0:3][NCH-1:0];
  w_t shadow_d [0:3][NCH-1:0];
  w_t active_q [0:3][NCH-1:0];
  w_t active_d [0:3][NCH-1:0];

  logic [1:0]    wr_set;
  logic [CW-1:0] wr_ch;

  assign wr_set = wr_idx[IW-1:CW];
  assign wr_ch  = wr_idx[CW-1:0];

  // Shadow bank: single write port, word stored unmodified.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_set][wr_ch] = w_t'(wr_data);
    end
  end

  // Active bank: whole-bank copy on commit so consumers never see a mixed set.
  always_comb begin
    active_d = active_q;
    if (commit) begin
      active_d = shadow_q;
    end
  end

  // Register both banks; reset is the only thing that clears the shadow bank.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign w_cos_1 = active_q[SET_COS1];
  assign w_sin_1 = active_q[SET_SIN1];
  assign w_cos_2 = active_q[SET_COS2];
  assign w_sin_2 = active_q[SET_SIN2];

endmodule

// File: rtl/bf_weight_loader.sv
// Double-buffered steering-weight loader: frame FSM, word counter, error flag and commit counter.
module bf_weight_loader #(
  parameter int unsigned NCH = bf_pkg::NCH,
  parameter int unsigned WW  = bf_pkg::WW
) (
  input  logic                 clock,
  input  logic                 reset,
  bf_weight_loader_if.slave    bus,
  input  logic                 apply,
  output logic signed [WW-1:0] w_cos_1 [NCH-1:0],
  output logic signed [WW-1:0] w_sin_1 [NCH-1:0],
  output logic signed [WW-1:0] w_cos_2 [NCH-1:0],
  output logic signed [WW-1:0] w_sin_2 [NCH-1:0],
  output logic                 full,
  output logic                 frame_err,
  output logic [7:0]           upd_cnt
);

  import bf_pkg::*;

  localparam int unsigned IW       = $clog2(4 * NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(4 * NCH - 1);

  bf_state_e     state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    upd_cnt_q, upd_cnt_d;

  logic          accept;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          commit;

  // Ready is gated by reset directly so it is low for the whole reset period.
  assign bus.s_ready = reset && (state_q != FULL);
  assign accept      = bus.s_valid && bus.s_ready;

  // Next-state, shadow write and commit decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    upd_cnt_d   = upd_cnt_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    commit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.s_sof) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            cnt_d   = IW'(1);
            state_d = LOAD;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.s_sof) begin
            frame_err_d = 1'b1;
            wr_idx      = '0;
            cnt_d       = IW'(1);
          end else begin
            wr_idx = cnt_q;
            cnt_d  = cnt_q + IW'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = FULL;
            end
          end
        end
      end
      FULL: begin
        if (apply) begin
          commit      = 1'b1;
          upd_cnt_d   = upd_cnt_q + 8'd1;
          frame_err_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      upd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  assign full      = (state_q == FULL);
  assign frame_err = frame_err_q;
  assign upd_cnt   = upd_cnt_q;

  bf_weight_bank #(
    .NCH (NCH),
    .WW  (WW),
    .IW  (IW)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (bus.s_data),
    .commit  (commit),
    .w_cos_1 (w_cos_1),
    .w_sin_1 (w_sin_1),
    .w_cos_2 (w_cos_2),
    .w_sin_2 (w_sin_2)
  );

endmodule
